// File: rtl/ls_pkg.sv
// Shared constants and FSM state type for the load/store execution unit.
package ls_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 6;
  localparam int IMM_W_DEF  = 16;

  localparam logic [5:0] OP_LW = 6'h23;
  localparam logic [5:0] OP_SW = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AGEN = 2'd1,
    MEM  = 2'd2,
    WB   = 2'd3
  } ls_state_e;

endpackage

// File: rtl/ls_agen.sv
// Effective-address generation: base + sign-extended offset, plus alignment
// and opcode legality check.
module ls_agen
  import ls_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [IMM_W-1:0]  imm,
  output logic [DATA_W-1:0] addr,
  output logic              exc
);

  logic [DATA_W-1:0] imm_sext;

  assign imm_sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  // Plain modular add: address wrap-around is legal and never traps.
  assign addr = rs_data + imm_sext;
  assign exc  = (addr[1:0] != 2'b00) || !((opcode == OP_LW) || (opcode == OP_SW));

endmodule

// File: rtl/ls_exec_unit.sv
// Single-op load/store execution unit: AGEN -> data-memory handshake ->
// CDB arbitration and one-cycle broadcast.
module ls_exec_unit
  import ls_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF,
  parameter int IMM_W  = IMM_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [5:0]        issue_opcode,
  input  logic [DATA_W-1:0] issue_rs_data,
  input  logic [DATA_W-1:0] issue_rt_data,
  input  logic [IMM_W-1:0]  issue_imm,
  input  logic [TAG_W-1:0]  issue_tag,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic              cdb_valid,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_exc
);

  ls_state_e state_reg, state_next;

  logic [5:0]        opcode_reg;
  logic [DATA_W-1:0] rs_reg;
  logic [DATA_W-1:0] rt_reg;
  logic [IMM_W-1:0]  imm_reg;
  logic [TAG_W-1:0]  tag_reg;
  logic              exc_reg;
  logic [DATA_W-1:0] rdata_reg;

  logic              dmem_we_reg;
  logic [DATA_W-1:0] dmem_addr_reg;
  logic [DATA_W-1:0] dmem_wdata_reg;

  logic              cdb_valid_reg;
  logic [DATA_W-1:0] cdb_data_reg;
  logic [TAG_W-1:0]  cdb_tag_reg;
  logic              cdb_exc_reg;

  logic [DATA_W-1:0] agen_addr;
  logic              agen_exc;

  ls_agen #(
    .DATA_W(DATA_W),
    .IMM_W (IMM_W)
  ) u_agen (
    .opcode (opcode_reg),
    .rs_data(rs_reg),
    .imm    (imm_reg),
    .addr   (agen_addr),
    .exc    (agen_exc)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    issue_ready = 1'b0;
    dmem_req    = 1'b0;
    cdb_req     = 1'b0;
    case (state_reg)
      IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) state_next = AGEN;
      end
      AGEN: state_next = agen_exc ? WB : MEM;
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_ack) state_next = WB;
      end
      WB: begin
        cdb_req = 1'b1;
        if (cdb_grant) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opcode_reg     <= '0;
      rs_reg         <= '0;
      rt_reg         <= '0;
      imm_reg        <= '0;
      tag_reg        <= '0;
      exc_reg        <= 1'b0;
      rdata_reg      <= '0;
      dmem_we_reg    <= 1'b0;
      dmem_addr_reg  <= '0;
      dmem_wdata_reg <= '0;
      cdb_valid_reg  <= 1'b0;
      cdb_data_reg   <= '0;
      cdb_tag_reg    <= '0;
      cdb_exc_reg    <= 1'b0;
    end else begin
      cdb_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (issue_valid) begin
            opcode_reg <= issue_opcode;
            rs_reg     <= issue_rs_data;
            rt_reg     <= issue_rt_data;
            imm_reg    <= issue_imm;
            tag_reg    <= issue_tag;
          end
        end
        AGEN: begin
          exc_reg <= agen_exc;
          // Memory-side registers only move for a legal access, so they stay
          // frozen for the whole MEM phase.
          if (!agen_exc) begin
            dmem_we_reg    <= (opcode_reg == OP_SW);
            dmem_addr_reg  <= agen_addr;
            dmem_wdata_reg <= rt_reg;
          end
        end
        MEM: begin
          if (dmem_ack && (opcode_reg == OP_LW)) rdata_reg <= dmem_rdata;
        end
        WB: begin
          if (cdb_grant) begin
            cdb_valid_reg <= 1'b1;
            cdb_tag_reg   <= tag_reg;
            cdb_exc_reg   <= exc_reg;
            cdb_data_reg  <= (exc_reg || (opcode_reg != OP_LW)) ? '0 : rdata_reg;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_we    = dmem_we_reg;
  assign dmem_addr  = dmem_addr_reg;
  assign dmem_wdata = dmem_wdata_reg;
  assign cdb_valid  = cdb_valid_reg;
  assign cdb_data   = cdb_data_reg;
  assign cdb_tag    = cdb_tag_reg;
  assign cdb_exc    = cdb_exc_reg;

endmodule

// File: tb/tb_ls_exec_unit.sv
// Directed self-checking bench for ls_exec_unit: cycle-exact LW/SW/exception,
// wrap-around, CDB backpressure and mid-access reset scenarios.
module tb_ls_exec_unit;

  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;
  localparam int IMM_W  = 16;

  logic              clk;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [5:0]        issue_opcode;
  logic [DATA_W-1:0] issue_rs_data;
  logic [DATA_W-1:0] issue_rt_data;
  logic [IMM_W-1:0]  issue_imm;
  logic [TAG_W-1:0]  issue_tag;
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_ack;
  logic [DATA_W-1:0] dmem_rdata;
  logic              cdb_req;
  logic              cdb_grant;
  logic              cdb_valid;
  logic [DATA_W-1:0] cdb_data;
  logic [TAG_W-1:0]  cdb_tag;
  logic              cdb_exc;

  int checks = 0;
  int errors = 0;

  ls_exec_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W), .IMM_W(IMM_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_opcode (issue_opcode),
    .issue_rs_data(issue_rs_data),
    .issue_rt_data(issue_rt_data),
    .issue_imm    (issue_imm),
    .issue_tag    (issue_tag),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .cdb_req      (cdb_req),
    .cdb_grant    (cdb_grant),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_tag      (cdb_tag),
    .cdb_exc      (cdb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [15:0] imm, input logic [5:0] tag);
    issue_valid   = 1'b1;
    issue_opcode  = op;
    issue_rs_data = rs;
    issue_rt_data = rt;
    issue_imm     = imm;
    issue_tag     = tag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({issue_ready, dmem_req, dmem_we, cdb_req, cdb_valid, cdb_exc} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl got ready/req/we/creq/cval/exc=%b want 100000",
               {issue_ready, dmem_req, dmem_we, cdb_req, cdb_valid, cdb_exc});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, cdb_data, cdb_tag} !== '0) begin
      errors++;
      $display("FAIL reset_data got addr=%h wdata=%h cdata=%h ctag=%0d want all zero",
               dmem_addr, dmem_wdata, cdb_data, cdb_tag);
    end
    rst = 1'b0;
    tick();
    $display("reset: ready=%b dmem_req=%b cdb_valid=%b", issue_ready, dmem_req, cdb_valid);
  endtask

  task automatic test_lw_basic();
    cdb_grant = 1'b1;
    present(6'h23, 32'h1000, 32'h0, 16'h0004, 6'd5);
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++; $display("FAIL lw_accept_ready got %b want 1", issue_ready);
    end
    tick();                       // cycle 1: AGEN
    issue_valid = 1'b0;
    checks++;
    if (issue_ready !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL lw_agen got ready=%b req=%b want 0 0", issue_ready, dmem_req);
    end
    tick();                       // cycle 2: MEM
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h1004) begin
      errors++;
      $display("FAIL lw_mem got req=%b we=%b addr=%h want 1 0 00001004", dmem_req, dmem_we, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    tick();                       // cycle 3: WB
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    checks++;
    if (cdb_req !== 1'b1 || dmem_req !== 1'b0 || cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL lw_wb got creq=%b dreq=%b cval=%b want 1 0 0", cdb_req, dmem_req, cdb_valid);
    end
    tick();                       // cycle 4: broadcast
    checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'hDEADBEEF || cdb_tag !== 6'd5 || cdb_exc !== 1'b0) begin
      errors++;
      $display("FAIL lw_cdb got val=%b data=%h tag=%0d exc=%b want 1 deadbeef 5 0",
               cdb_valid, cdb_data, cdb_tag, cdb_exc);
    end
    $display("lw_basic: cdb_valid=%b data=%h tag=%0d", cdb_valid, cdb_data, cdb_tag);
    tick();
    checks++;
    if (cdb_valid !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL lw_pulse got val=%b ready=%b want 0 1", cdb_valid, issue_ready);
    end
  endtask

  task automatic test_sw_delayed_ack();
    int req_cycles = 0;
    cdb_grant = 1'b1;
    present(6'h2B, 32'h2000, 32'h12345678, 16'hFFFC, 6'd9);
    tick();                       // cycle 1: AGEN
    issue_valid = 1'b0;
    tick();                       // cycle 2..5: MEM, ack in the 4th MEM cycle
    for (int c = 0; c < 4; c++) begin
      if (dmem_req === 1'b1) req_cycles++;
      checks++;
      if (dmem_we !== 1'b1 || dmem_addr !== 32'h1FFC || dmem_wdata !== 32'h12345678) begin
        errors++;
        $display("FAIL sw_mem_stable c=%0d got we=%b addr=%h wdata=%h want 1 00001ffc 12345678",
                 c, dmem_we, dmem_addr, dmem_wdata);
      end
      dmem_ack = (c == 3);
      tick();
    end
    dmem_ack = 1'b0;
    checks++;
    if (req_cycles != 4 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL sw_req_len got %0d cycles then req=%b want 4 then 0", req_cycles, dmem_req);
    end
    tick();                       // broadcast
    checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'h0 || cdb_tag !== 6'd9 || cdb_exc !== 1'b0) begin
      errors++;
      $display("FAIL sw_cdb got val=%b data=%h tag=%0d exc=%b want 1 00000000 9 0",
               cdb_valid, cdb_data, cdb_tag, cdb_exc);
    end
    $display("sw_delayed_ack: req_cycles=%0d cdb_tag=%0d data=%h", req_cycles, cdb_tag, cdb_data);
    tick();
  endtask

  task automatic test_exceptions();
    logic [5:0] ops [2];
    logic [31:0] bases [2];
    ops[0] = 6'h23; bases[0] = 32'h1001;   // misaligned LW
    ops[1] = 6'h00; bases[1] = 32'h1000;   // aligned but illegal opcode
    cdb_grant = 1'b1;
    for (int k = 0; k < 2; k++) begin
      present(ops[k], bases[k], 32'hFFFF_FFFF, 16'h0000, 6'(20 + k));
      tick();                     // cycle 1: AGEN
      issue_valid = 1'b0;
      checks++;
      if (dmem_req !== 1'b0) begin
        errors++; $display("FAIL exc%0d_agen_req got %b want 0", k, dmem_req);
      end
      dmem_ack = 1'b1;            // stray ack must be ignored
      tick();                     // cycle 2: WB
      dmem_ack = 1'b0;
      checks++;
      if (dmem_req !== 1'b0 || cdb_req !== 1'b1) begin
        errors++; $display("FAIL exc%0d_wb got dreq=%b creq=%b want 0 1", k, dmem_req, cdb_req);
      end
      tick();                     // cycle 3: broadcast
      checks++;
      if (cdb_valid !== 1'b1 || cdb_exc !== 1'b1 || cdb_data !== 32'h0 || cdb_tag !== 6'(20 + k)) begin
        errors++;
        $display("FAIL exc%0d_cdb got val=%b exc=%b data=%h tag=%0d want 1 1 00000000 %0d",
                 k, cdb_valid, cdb_exc, cdb_data, cdb_tag, 20 + k);
      end
      $display("exception %0d: cdb_valid=%b exc=%b tag=%0d", k, cdb_valid, cdb_exc, cdb_tag);
      tick();
    end
  endtask

  task automatic test_addr_wrap();
    cdb_grant = 1'b1;
    present(6'h23, 32'hFFFF_FFFC, 32'h0, 16'h0008, 6'd33);
    tick();
    issue_valid = 1'b0;
    tick();                       // MEM
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h0000_0004) begin
      errors++; $display("FAIL wrap_addr got req=%b addr=%h want 1 00000004", dmem_req, dmem_addr);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_0004;
    tick();
    dmem_ack = 1'b0;
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_data !== 32'hCAFE_0004 || cdb_tag !== 6'd33 || cdb_exc !== 1'b0) begin
      errors++;
      $display("FAIL wrap_cdb got val=%b data=%h tag=%0d exc=%b want 1 cafe0004 33 0",
               cdb_valid, cdb_data, cdb_tag, cdb_exc);
    end
    $display("addr_wrap: addr=%h cdb_data=%h", dmem_addr, cdb_data);
    tick();
  endtask

  task automatic test_back_to_back();
    cdb_grant = 1'b0;
    present(6'h23, 32'h0100, 32'h0, 16'h0000, 6'd3);
    tick();                       // cycle 1: AGEN; queue now shows the next op
    present(6'h2B, 32'h0300, 32'h0000_0055, 16'h0004, 6'd7);
    tick();                       // cycle 2: MEM
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_A5A5;
    tick();                       // cycles 3..7: WB without grant
    dmem_ack = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (cdb_req !== 1'b1 || issue_ready !== 1'b0 || cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL b2b_hold c=%0d got creq=%b ready=%b val=%b want 1 0 0",
                 c, cdb_req, issue_ready, cdb_valid);
      end
      tick();
    end
    cdb_grant = 1'b1;             // cycle 8: grant
    checks++;
    if (cdb_req !== 1'b1 || issue_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_grant_cycle got creq=%b ready=%b want 1 0", cdb_req, issue_ready);
    end
    tick();                       // cycle 9: broadcast + accept second op
    checks++;
    if (cdb_valid !== 1'b1 || issue_ready !== 1'b1 || cdb_data !== 32'h0000_A5A5 || cdb_tag !== 6'd3) begin
      errors++;
      $display("FAIL b2b_first_cdb got val=%b ready=%b data=%h tag=%0d want 1 1 0000a5a5 3",
               cdb_valid, issue_ready, cdb_data, cdb_tag);
    end
    tick();                       // cycle 10: second op in AGEN
    issue_valid = 1'b0;
    checks++;
    if (issue_ready !== 1'b0 || cdb_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept got ready=%b val=%b want 0 0", issue_ready, cdb_valid);
    end
    tick();                       // cycle 11: second op in MEM
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h0304 || dmem_wdata !== 32'h55) begin
      errors++;
      $display("FAIL b2b_second_mem got req=%b we=%b addr=%h wdata=%h want 1 1 00000304 00000055",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ack = 1'b1;
    tick();
    dmem_ack = 1'b0;
    tick();
    checks++;
    if (cdb_valid !== 1'b1 || cdb_tag !== 6'd7 || cdb_data !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second_cdb got val=%b tag=%0d data=%h want 1 7 00000000", cdb_valid, cdb_tag, cdb_data);
    end
    $display("back_to_back: second op tag=%0d completed", cdb_tag);
    tick();
  endtask

  task automatic test_reset_during_mem();
    int seen_valid = 0;
    cdb_grant = 1'b1;
    present(6'h23, 32'h4000, 32'h0, 16'h0010, 6'd44);
    tick();
    issue_valid = 1'b0;
    tick();                       // MEM
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rstmem_pre got req=%b want 1", dmem_req);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (dmem_req !== 1'b0 || issue_ready !== 1'b1) begin
      errors++; $display("FAIL rstmem_post got req=%b ready=%b want 0 1", dmem_req, issue_ready);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h1111_2222;   // late ack
    tick();
    dmem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (cdb_valid === 1'b1 || cdb_req === 1'b1 || dmem_req === 1'b1) seen_valid++;
      tick();
    end
    checks++;
    if (seen_valid != 0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmem_quiet got %0d busy cycles ready=%b want 0 1", seen_valid, issue_ready);
    end
    $display("reset_during_mem: ready=%b busy_cycles=%0d", issue_ready, seen_valid);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0;
    issue_opcode = '0;
    issue_rs_data = '0;
    issue_rt_data = '0;
    issue_imm = '0;
    issue_tag = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    cdb_grant = 1'b0;
    test_reset();
    test_lw_basic();
    test_sw_delayed_ack();
    test_exceptions();
    test_addr_wrap();
    test_back_to_back();
    test_reset_during_mem();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
